// File: rtl/stream_mux_rr_pkg.sv
// stream_mux_rr_pkg: mode encoding and select-width helpers shared by the stream mux files
package stream_mux_rr_pkg;
  typedef enum logic {MODE_FIXED = 1'b0, MODE_RR = 1'b1} mode_e;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction
  function automatic int sel_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction
endpackage

// File: rtl/stream_mux_rr_if.sv
// stream_mux_rr_if: N_CH-input valid/ready bus (in_data/in_valid/in_ready, sel, mode_rr) plus registered output (out_data/out_ch/out_valid/out_ready); master = producers+consumer, slave = mux
interface stream_mux_rr_if #(
  parameter int N_CH = 8,
  parameter int W = 8
);
  import stream_mux_rr_pkg::*;
  localparam int SELW = sel_w(N_CH);
  logic [N_CH*W-1:0] in_data;
  logic [N_CH-1:0] in_valid;
  logic [N_CH-1:0] in_ready;
  logic [SELW-1:0] sel;
  logic mode_rr;
  logic [W-1:0] out_data;
  logic [SELW-1:0] out_ch;
  logic out_valid;
  logic out_ready;
  modport master (
    output in_data, in_valid, sel, mode_rr, out_ready,
    input in_ready, out_data, out_ch, out_valid
  );
  modport slave (
    input in_data, in_valid, sel, mode_rr, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );
endinterface

// File: rtl/stream_mux_rr_arbiter.sv
// stream_mux_rr_arbiter: combinational grant (req, ptr, en_fixed, sel -> one-hot grant, grant_idx, hit) via rotate-by-(ptr+1) and lowest-bit priority encode
module stream_mux_rr_arbiter
  import stream_mux_rr_pkg::*;
#(
  parameter int N_CH = 8,
  localparam int SELW = sel_w(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [SELW-1:0] ptr,
  input  logic [SELW-1:0] sel,
  input  logic            en_fixed,
  output logic [N_CH-1:0] grant,
  output logic [SELW-1:0] grant_idx,
  output logic            hit
);
  localparam logic [SELW:0] NC = (SELW + 1)'(N_CH);
  logic [SELW-1:0] start, off;
  logic [N_CH-1:0] rot;
  logic [SELW:0] sum;
  logic rr_hit, fix_hit;
  always_comb begin
    start = (ptr == SELW'(N_CH - 1)) ? '0 : ptr + SELW'(1);
    rot = N_CH'({req, req} >> start);
    rr_hit = 1'b0;
    off = '0;
    for (int i = N_CH - 1; i >= 0; i--)
      if (rot[i]) begin
        rr_hit = 1'b1;
        off = SELW'(i);
      end
    sum = {1'b0, start} + {1'b0, off};
    sum = (sum >= NC) ? sum - NC : sum;
    fix_hit = 1'b0;
    for (int k = 0; k < N_CH; k++)
      if (sel == SELW'(k) && req[k]) fix_hit = 1'b1;
    hit = en_fixed ? fix_hit : rr_hit;
    grant_idx = en_fixed ? sel : sum[SELW-1:0];
    grant = '0;
    for (int k = 0; k < N_CH; k++) grant[k] = hit && grant_idx == SELW'(k);
  end
endmodule

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N_CH x W stream mux, fixed-select or round-robin, single registered output stage (clk, rst, bus: stream_mux_rr_if.slave)
module stream_mux_rr
  import stream_mux_rr_pkg::*;
#(
  parameter int N_CH = 8,
  parameter int W = 8
) (
  input logic clk,
  input logic rst,
  stream_mux_rr_if.slave bus
);
  localparam int SELW = sel_w(N_CH);
  logic load_en, hit;
  logic [N_CH-1:0] grant;
  logic [SELW-1:0] gidx, rr_ptr;
  logic [W-1:0] win;
  stream_mux_rr_arbiter #(.N_CH(N_CH)) u_arb (
    .req(bus.in_valid),
    .ptr(rr_ptr),
    .sel(bus.sel),
    .en_fixed(bus.mode_rr == MODE_FIXED),
    .grant(grant),
    .grant_idx(gidx),
    .hit(hit)
  );
  assign load_en = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = (load_en && !rst) ? grant : '0;
  always_comb begin
    win = '0;
    for (int k = 0; k < N_CH; k++) if (grant[k]) win = bus.in_data[k*W +: W];
  end
  always_ff @(posedge clk)
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data <= '0;
      bus.out_ch <= '0;
      rr_ptr <= SELW'(N_CH - 1);
    end else if (load_en) begin
      bus.out_valid <= hit;
      if (hit) begin
        bus.out_data <= win;
        bus.out_ch <= gidx;
        rr_ptr <= gidx;
      end
    end
endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: randomized self-checking bench for stream_mux_rr against a queue-free behavioural model
module tb_stream_mux_rr;
  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;
  stream_mux_rr_if #(.N_CH(8), .W(8)) a ();
  stream_mux_rr_if #(.N_CH(5), .W(12)) b ();
  stream_mux_rr #(.N_CH(8), .W(8)) dut_a (.clk(clk), .rst(rst_a), .bus(a.slave));
  stream_mux_rr #(.N_CH(5), .W(12)) dut_b (.clk(clk), .rst(rst_b), .bus(b.slave));
  int checks = 0;
  int errors = 0;
  bit m_valid = 1'b0;
  logic [7:0] m_data = 8'h00;
  int m_ch = 0;
  int m_ptr = 7;
  function automatic int pick(input int n, input logic [15:0] v, input int ptr, input bit rr, input int s);
    if (!rr) return (s < n && v[s]) ? s : -1;
    for (int i = 1; i <= n; i++) if (v[(ptr + i) % n]) return (ptr + i) % n;
    return -1;
  endfunction
  function automatic logic [7:0] exp_ready_a();
    int g;
    g = pick(8, 16'(a.in_valid), m_ptr, a.mode_rr, int'(a.sel));
    if (rst_a || (m_valid && !a.out_ready) || g < 0) return 8'h00;
    return 8'(1 << g);
  endfunction
  task automatic tick_a();
    int g;
    bit le;
    logic [7:0] d;
    g = pick(8, 16'(a.in_valid), m_ptr, a.mode_rr, int'(a.sel));
    le = !m_valid || a.out_ready;
    d = 8'h00;
    if (g >= 0) d = a.in_data[g*8 +: 8];
    @(posedge clk);
    if (rst_a) begin
      m_valid = 1'b0;
      m_data = 8'h00;
      m_ch = 0;
      m_ptr = 7;
    end else if (le) begin
      m_valid = (g >= 0);
      if (g >= 0) begin
        m_data = d;
        m_ch = g;
        m_ptr = g;
      end
    end
    @(negedge clk);
  endtask
  task automatic test_reset();
    a.in_valid = 8'hFF;
    a.mode_rr = 1'b1;
    a.out_ready = 1'b1;
    a.sel = 3'd0;
    a.in_data = {$urandom, $urandom};
    rst_a = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (a.in_ready !== 8'h00) begin errors++; $display("FAIL reset_ready got %h want 00", a.in_ready); end
      tick_a();
    end
    #1;
    checks++;
    if (a.out_valid !== 1'b0 || a.out_data !== 8'h00 || a.out_ch !== 3'd0) begin
      errors++;
      $display("FAIL reset_out got v=%b d=%h ch=%0d want v=0 d=00 ch=0", a.out_valid, a.out_data, a.out_ch);
    end
    rst_a = 1'b0;
  endtask
  task automatic test_fixed();
    a.mode_rr = 1'b0;
    a.sel = 3'd5;
    a.in_valid = 8'hFF;
    a.out_ready = 1'b1;
    a.in_data = {$urandom, $urandom};
    a.in_data[47:40] = 8'hA5;
    #1;
    checks++;
    if (a.in_ready !== 8'h20) begin errors++; $display("FAIL fixed_ready got %h want 20", a.in_ready); end
    tick_a();
    #1;
    checks++;
    if (a.out_valid !== 1'b1 || a.out_data !== 8'hA5 || a.out_ch !== 3'd5) begin
      errors++;
      $display("FAIL fixed_out got v=%b d=%h ch=%0d want v=1 d=a5 ch=5", a.out_valid, a.out_data, a.out_ch);
    end
    a.sel = 3'd7;
    a.in_valid = 8'h7F;
    #1;
    checks++;
    if (a.in_ready !== 8'h00) begin errors++; $display("FAIL fixed_nogrant_ready got %h want 00", a.in_ready); end
    tick_a();
    #1;
    checks++;
    if (a.out_valid !== 1'b0 || a.out_data !== 8'hA5 || a.out_ch !== 3'd5) begin
      errors++;
      $display("FAIL fixed_drop got v=%b d=%h ch=%0d want v=0 d=a5 ch=5", a.out_valid, a.out_data, a.out_ch);
    end
    for (int i = 0; i < 30; i++) begin
      a.sel = 3'($urandom_range(0, 7));
      a.in_valid = 8'($urandom);
      a.out_ready = ($urandom_range(0, 3) != 0);
      a.in_data = {$urandom, $urandom};
      #1;
      checks++;
      if (a.in_ready !== exp_ready_a()) begin errors++; $display("FAIL fixed_rand_ready got %h want %h", a.in_ready, exp_ready_a()); end
      tick_a();
      #1;
      checks++;
      if (a.out_valid !== m_valid || a.out_data !== m_data || a.out_ch !== 3'(m_ch)) begin
        errors++;
        $display("FAIL fixed_rand_out got v=%b d=%h ch=%0d want v=%b d=%h ch=%0d", a.out_valid, a.out_data, a.out_ch, m_valid, m_data, m_ch);
      end
    end
  endtask
  task automatic test_rr();
    rst_a = 1'b1;
    tick_a();
    rst_a = 1'b0;
    a.mode_rr = 1'b1;
    a.in_valid = 8'hFF;
    a.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      a.in_data = {$urandom, $urandom};
      #1;
      checks++;
      if (a.in_ready !== 8'(1 << (i % 8))) begin errors++; $display("FAIL rr_ready[%0d] got %h want %h", i, a.in_ready, 8'(1 << (i % 8))); end
      tick_a();
      #1;
      checks++;
      if (a.out_valid !== 1'b1 || a.out_ch !== 3'(i % 8) || a.out_data !== m_data) begin
        errors++;
        $display("FAIL rr_seq[%0d] got v=%b ch=%0d d=%h want v=1 ch=%0d d=%h", i, a.out_valid, a.out_ch, a.out_data, i % 8, m_data);
      end
    end
    a.in_valid = 8'h84;
    for (int i = 0; i < 6; i++) begin
      a.in_data = {$urandom, $urandom};
      tick_a();
      #1;
      checks++;
      if (a.out_valid !== 1'b1 || a.out_ch !== ((i % 2 == 0) ? 3'd2 : 3'd7)) begin
        errors++;
        $display("FAIL rr_alt[%0d] got v=%b ch=%0d want v=1 ch=%0d", i, a.out_valid, a.out_ch, (i % 2 == 0) ? 2 : 7);
      end
    end
  endtask
  task automatic test_backpressure();
    a.mode_rr = 1'b0;
    a.sel = 3'd3;
    a.in_valid = 8'h08;
    a.in_data = {$urandom, $urandom};
    a.in_data[31:24] = 8'h3C;
    a.out_ready = 1'b1;
    tick_a();
    a.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a.in_valid = 8'($urandom) | 8'h01;
      a.sel = 3'($urandom_range(0, 7));
      a.mode_rr = 1'($urandom);
      a.in_data = {$urandom, $urandom};
      #1;
      checks++;
      if (a.in_ready !== 8'h00 || a.out_valid !== 1'b1 || a.out_data !== 8'h3C || a.out_ch !== 3'd3) begin
        errors++;
        $display("FAIL stall[%0d] got rdy=%h v=%b d=%h ch=%0d want rdy=00 v=1 d=3c ch=3", i, a.in_ready, a.out_valid, a.out_data, a.out_ch);
      end
      tick_a();
    end
    a.mode_rr = 1'b0;
    a.sel = 3'd1;
    a.in_valid = 8'h02;
    a.in_data[15:8] = 8'h5A;
    a.out_ready = 1'b1;
    #1;
    checks++;
    if (a.in_ready !== 8'h02) begin errors++; $display("FAIL release_ready got %h want 02", a.in_ready); end
    tick_a();
    #1;
    checks++;
    if (a.out_valid !== 1'b1 || a.out_data !== 8'h5A || a.out_ch !== 3'd1) begin
      errors++;
      $display("FAIL release_out got v=%b d=%h ch=%0d want v=1 d=5a ch=1", a.out_valid, a.out_data, a.out_ch);
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      rst_a = ($urandom_range(0, 39) == 0);
      a.mode_rr = 1'($urandom);
      a.sel = 3'($urandom_range(0, 7));
      a.in_valid = 8'($urandom);
      a.out_ready = ($urandom_range(0, 2) != 0);
      a.in_data = {$urandom, $urandom};
      #1;
      checks++;
      if (a.in_ready !== exp_ready_a()) begin errors++; $display("FAIL rand_ready[%0d] got %h want %h", i, a.in_ready, exp_ready_a()); end
      tick_a();
      #1;
      checks++;
      if (a.out_valid !== m_valid || a.out_data !== m_data || a.out_ch !== 3'(m_ch)) begin
        errors++;
        $display("FAIL rand_out[%0d] got v=%b d=%h ch=%0d want v=%b d=%h ch=%0d", i, a.out_valid, a.out_data, a.out_ch, m_valid, m_data, m_ch);
      end
    end
    rst_a = 1'b0;
  endtask
  task automatic test_reset_mid();
    a.mode_rr = 1'b0;
    a.sel = 3'd6;
    a.in_valid = 8'h40;
    a.out_ready = 1'b1;
    tick_a();
    a.out_ready = 1'b0;
    tick_a();
    #1;
    checks++;
    if (a.out_valid !== 1'b1 || a.out_ch !== 3'd6) begin errors++; $display("FAIL midrst_hold got v=%b ch=%0d want v=1 ch=6", a.out_valid, a.out_ch); end
    rst_a = 1'b1;
    #1;
    checks++;
    if (a.in_ready !== 8'h00) begin errors++; $display("FAIL midrst_ready got %h want 00", a.in_ready); end
    tick_a();
    #1;
    checks++;
    if (a.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_drop got v=%b want 0", a.out_valid); end
    rst_a = 1'b0;
    a.mode_rr = 1'b1;
    a.in_valid = 8'hFF;
    a.out_ready = 1'b1;
    #1;
    checks++;
    if (a.in_ready !== 8'h01) begin errors++; $display("FAIL midrst_restart_ready got %h want 01", a.in_ready); end
    tick_a();
    #1;
    checks++;
    if (a.out_valid !== 1'b1 || a.out_ch !== 3'd0) begin errors++; $display("FAIL midrst_restart_out got v=%b ch=%0d want v=1 ch=0", a.out_valid, a.out_ch); end
  endtask
  task automatic test_small();
    logic [11:0] d;
    int ch;
    b.mode_rr = 1'b1;
    b.in_valid = 5'b10001;
    b.out_ready = 1'b1;
    b.sel = 3'd0;
    rst_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b.in_data = 60'({$urandom, $urandom});
      ch = (i % 2 == 0) ? 0 : 4;
      d = b.in_data[ch*12 +: 12];
      #1;
      checks++;
      if (b.in_ready !== 5'(1 << ch)) begin errors++; $display("FAIL small_rr_ready[%0d] got %h want %h", i, b.in_ready, 5'(1 << ch)); end
      @(posedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (b.out_valid !== 1'b1 || b.out_ch !== 3'(ch) || b.out_data !== d) begin
        errors++;
        $display("FAIL small_rr_out[%0d] got v=%b ch=%0d d=%h want v=1 ch=%0d d=%h", i, b.out_valid, b.out_ch, b.out_data, ch, d);
      end
    end
    b.mode_rr = 1'b0;
    b.in_valid = 5'h1F;
    for (int s = 4; s < 8; s++) begin
      b.sel = 3'(s);
      #1;
      checks++;
      if (b.in_ready !== ((s == 4) ? 5'h10 : 5'h00)) begin
        errors++;
        $display("FAIL small_fixed_sel%0d got %h want %h", s, b.in_ready, (s == 4) ? 5'h10 : 5'h00);
      end
    end
  endtask
  initial begin
    b.in_data = '0;
    b.in_valid = '0;
    b.sel = '0;
    b.mode_rr = 1'b0;
    b.out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_fixed();
    test_rr();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_small();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
